memory_mapped_regs: RTL and testbench
=====================================

# memory_mapped_regs

Memory-mapped configuration/status register file for the MPEG2-TS QoS channel-selection controller. It sits between the host bus (simple write/read strobes, 8-bit address, 32-bit data) and the main control FSM: it holds the configuration outputs (fallback, manual mode/channel, channel priority order, reset timer) and exposes live status (active channel, signal presence, per-channel error counts) for readback.

## Interface
Parameters: none.
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- mm_write_en  input  1  write strobe, one write per cycle when high
- mm_read_en  input  1  read strobe
- mm_addr  input  8  byte address, shared by read and write
- mm_wdata  input  32  write data
- mm_rdata  output  32  registered read data
- fallback_enable  output  1  CONTROL[0]
- manual_enable  output  1  CONTROL[1]
- manual_channel  output  2  CONTROL[5:4]
- channel_priority  output  8  PRIORITY[7:0]; [1:0] = highest-priority channel, [7:6] = lowest
- reset_timer  output  20  RESET_TIMER[19:0], cycles between auto re-selections
- active_channel  input  2  channel currently driven to mux
- signal_present  input  4  per-channel valid, bit n = channel n
- error_count_ch0..error_count_ch3  input  8 each  per-channel error counters

## Operation
Register map (word addresses; any other address, including non-multiple-of-4, is unmapped):
- 0x00 CONTROL RW: [0] fallback_enable, [1] manual_enable, [5:4] manual_channel; other bits reserved. Reset 0x00000000.
- 0x04 PRIORITY RW: [7:0] channel_priority. Reset 0x000000E4 (order ch0,ch1,ch2,ch3).
- 0x08 RESET_TIMER RW: [19:0] reset_timer. Reset 0x000003E8 (1000).
- 0x0C STATUS RO: [1:0] active_channel, [7:4] signal_present.
- 0x10 ERR_COUNT RO: {error_count_ch3, error_count_ch2, error_count_ch1, error_count_ch0}.
- 0x1C ID RO (see Configuration).
Rules:
- Write: when mm_write_en high, the addressed RW register loads the relevant mm_wdata bits; reserved bits are discarded.
- Writes to RO or unmapped addresses have no effect.
- Reserved/unused bits always read 0; unmapped addresses read 0x00000000.
- Configuration outputs are driven directly from the register flops (no combinational path from bus).
- Priority field not checked for duplicates; reset_timer value 0 stored as-is.
- Status/counter reads sample the live inputs at the clock edge of the read.

## Timing
- Write: register updates on the rising edge where mm_write_en=1; new value visible on outputs the following cycle (1-cycle latency).
- Read: mm_rdata loads on the rising edge where mm_read_en=1; valid from the next cycle; holds its value while mm_read_en=0.
- Simultaneous read and write to the same address: read returns the pre-write value; write takes effect normally.
- Reset (synchronous, including mid-transaction): all RW registers to reset values above, mm_rdata = 0; a strobe in a reset cycle is ignored.

## Configuration
- Macro MM_ID_REG_EN: when defined, address 0x1C is RO and returns constant 0x4D505453 ("MPTS"). When not defined, 0x1C is unmapped and reads 0x00000000.

## Test plan
- After rst: outputs fallback=0, manual=0, manual_channel=0, channel_priority=0xE4, reset_timer=1000; read 0x08 -> 0x000003E8.
- Write 0x00 <- 0xFFFFFFFF -> fallback=1, manual=1, manual_channel=3 next cycle; read 0x00 -> 0x00000033.
- Write 0x04 <- 0x1B, 0x08 <- 0xFFFFFFFF -> channel_priority=0x1B, reset_timer=0xFFFFF; readback 0x0000001B / 0x000FFFFF.
- Inputs active_channel=2, signal_present=0xA, errs ch0..3 = 0x01,0x02,0x03,0x04 -> read 0x0C = 0x000000A2, read 0x10 = 0x04030201.
- Write 0x0C, 0x10, 0x03, 0x40 <- 0x12345678 -> no output change; reads of 0x03/0x40 return 0; 0x1C returns 0x4D505453 only with MM_ID_REG_EN.
- Same-cycle read+write 0x08 (old 1000, new 5) -> mm_rdata=0x3E8, then reset_timer=5; assert rst mid-sequence -> all back to reset values, mm_rdata=0.

Source files
------------

// File: rtl/memory_mapped_regs.sv
// Host-visible configuration/status register file for the TS QoS channel selector.
// Optional build macro MM_ID_REG_EN maps a constant ID word at 0x1C.
module memory_mapped_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        mm_write_en,
    input  logic        mm_read_en,
    input  logic [7:0]  mm_addr,
    input  logic [31:0] mm_wdata,
    output logic [31:0] mm_rdata,
    output logic        fallback_enable,
    output logic        manual_enable,
    output logic [1:0]  manual_channel,
    output logic [7:0]  channel_priority,
    output logic [19:0] reset_timer,
    input  logic [1:0]  active_channel,
    input  logic [3:0]  signal_present,
    input  logic [7:0]  error_count_ch0,
    input  logic [7:0]  error_count_ch1,
    input  logic [7:0]  error_count_ch2,
    input  logic [7:0]  error_count_ch3
);
    localparam logic [7:0]  ADDR_CONTROL  = 8'h00;
    localparam logic [7:0]  ADDR_PRIORITY = 8'h04;
    localparam logic [7:0]  ADDR_TIMER    = 8'h08;
    localparam logic [7:0]  ADDR_STATUS   = 8'h0C;
    localparam logic [7:0]  ADDR_ERR      = 8'h10;
    localparam logic [7:0]  ADDR_ID       = 8'h1C;
    localparam logic [31:0] ID_VALUE      = 32'h4D50_5453;

    localparam logic [7:0]  PRIORITY_RST  = 8'hE4;
    localparam logic [19:0] TIMER_RST     = 20'd1000;

    logic        fallback_reg;
    logic        manual_reg;
    logic [1:0]  channel_reg;
    logic [7:0]  priority_reg;
    logic [19:0] timer_reg;
    logic [31:0] rdata_reg;
    logic [31:0] rdata_next;
    logic [31:0] err_word;
    logic [7:0]  err_arr [4];

    assign err_arr[0] = error_count_ch0;
    assign err_arr[1] = error_count_ch1;
    assign err_arr[2] = error_count_ch2;
    assign err_arr[3] = error_count_ch3;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_err
            assign err_word[gi*8 +: 8] = err_arr[gi];
        end
    endgenerate

    // Read mux sees register state before any same-cycle write lands.
    always_comb begin
        rdata_next = 32'h0;
        case (mm_addr)
            ADDR_CONTROL:  rdata_next = {26'h0, channel_reg, 2'b00, manual_reg, fallback_reg};
            ADDR_PRIORITY: rdata_next = {24'h0, priority_reg};
            ADDR_TIMER:    rdata_next = {12'h0, timer_reg};
            ADDR_STATUS:   rdata_next = {24'h0, signal_present, 2'b00, active_channel};
            ADDR_ERR:      rdata_next = err_word;
`ifdef MM_ID_REG_EN
            ADDR_ID:       rdata_next = ID_VALUE;
`else
            ADDR_ID:       rdata_next = 32'h0;
`endif
            default:       rdata_next = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fallback_reg <= 1'b0;
            manual_reg   <= 1'b0;
            channel_reg  <= 2'd0;
            priority_reg <= PRIORITY_RST;
            timer_reg    <= TIMER_RST;
            rdata_reg    <= 32'h0;
        end else begin
            if (mm_read_en) begin
                rdata_reg <= rdata_next;
            end
            if (mm_write_en) begin
                case (mm_addr)
                    ADDR_CONTROL: begin
                        fallback_reg <= mm_wdata[0];
                        manual_reg   <= mm_wdata[1];
                        channel_reg  <= mm_wdata[5:4];
                    end
                    ADDR_PRIORITY: priority_reg <= mm_wdata[7:0];
                    ADDR_TIMER:    timer_reg    <= mm_wdata[19:0];
                    default: ;
                endcase
            end
        end
    end

    assign mm_rdata         = rdata_reg;
    assign fallback_enable  = fallback_reg;
    assign manual_enable    = manual_reg;
    assign manual_channel   = channel_reg;
    assign channel_priority = priority_reg;
    assign reset_timer      = timer_reg;
endmodule

// File: tb/tb_memory_mapped_regs.sv
// Bench for memory_mapped_regs: directed register-map checks then random traffic
// against a field-level reference model.
module tb_memory_mapped_regs;
    logic        clk = 1'b0;
    logic        rst;
    logic        mm_write_en;
    logic        mm_read_en;
    logic [7:0]  mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;
    logic        fallback_enable;
    logic        manual_enable;
    logic [1:0]  manual_channel;
    logic [7:0]  channel_priority;
    logic [19:0] reset_timer;
    logic [1:0]  active_channel;
    logic [3:0]  signal_present;
    logic [7:0]  error_count_ch0, error_count_ch1, error_count_ch2, error_count_ch3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept as individual fields
    bit        m_fb, m_man;
    bit [1:0]  m_ch;
    bit [7:0]  m_prio;
    bit [19:0] m_timer;
    bit [31:0] m_rdata;

    memory_mapped_regs dut (
        .clk(clk), .rst(rst),
        .mm_write_en(mm_write_en), .mm_read_en(mm_read_en),
        .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata),
        .fallback_enable(fallback_enable), .manual_enable(manual_enable),
        .manual_channel(manual_channel), .channel_priority(channel_priority),
        .reset_timer(reset_timer), .active_channel(active_channel),
        .signal_present(signal_present),
        .error_count_ch0(error_count_ch0), .error_count_ch1(error_count_ch1),
        .error_count_ch2(error_count_ch2), .error_count_ch3(error_count_ch3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] model_read(input bit [7:0] a);
        case (a)
            8'h00: return 32'(m_fb) + 32'(m_man) * 2 + 32'(m_ch) * 16;
            8'h04: return 32'(m_prio);
            8'h08: return 32'(m_timer);
            8'h0C: return 32'(active_channel) + 32'(signal_present) * 16;
            8'h10: return {error_count_ch3, error_count_ch2, error_count_ch1, error_count_ch0};
`ifdef MM_ID_REG_EN
            8'h1C: return 32'h4D505453;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_fb = 0; m_man = 0; m_ch = 0; m_prio = 8'hE4; m_timer = 20'd1000; m_rdata = 0;
        end else begin
            if (mm_read_en) m_rdata = model_read(mm_addr);
            if (mm_write_en) begin
                if (mm_addr == 8'h00) begin
                    m_fb = mm_wdata[0]; m_man = mm_wdata[1]; m_ch = mm_wdata[5:4];
                end else if (mm_addr == 8'h04) m_prio = mm_wdata[7:0];
                else if (mm_addr == 8'h08) m_timer = mm_wdata[19:0];
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rdata"}, mm_rdata, m_rdata);
        check({tag, ".ctrl"}, {26'h0, manual_channel, 2'b00, manual_enable, fallback_enable},
              32'(m_fb) + 32'(m_man) * 2 + 32'(m_ch) * 16);
        check({tag, ".prio"}, 32'(channel_priority), 32'(m_prio));
        check({tag, ".timer"}, 32'(reset_timer), 32'(m_timer));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic bus(input bit we, input bit re, input bit [7:0] a, input bit [31:0] d);
        mm_write_en = we; mm_read_en = re; mm_addr = a; mm_wdata = d;
        tick();
        $display("txn we=%0d re=%0d addr=0x%02h wdata=0x%08h rdata=0x%08h", we, re, a, d, mm_rdata);
    endtask

    task automatic idle();
        bus(0, 0, 8'h00, 32'h0);
    endtask

    initial begin
        rst = 1; mm_write_en = 0; mm_read_en = 0; mm_addr = 0; mm_wdata = 0;
        active_channel = 0; signal_present = 0;
        error_count_ch0 = 0; error_count_ch1 = 0; error_count_ch2 = 0; error_count_ch3 = 0;
        tick(); tick();
        rst = 0;
        check("rst_fallback", 32'(fallback_enable), 32'h0);
        check("rst_manual", 32'(manual_enable), 32'h0);
        check("rst_mch", 32'(manual_channel), 32'h0);
        check("rst_prio", 32'(channel_priority), 32'hE4);
        check("rst_timer", 32'(reset_timer), 32'd1000);
        check("rst_rdata", mm_rdata, 32'h0);
        bus(0, 1, 8'h08, 0);
        check("rd_timer_rst", mm_rdata, 32'h3E8);

        bus(1, 0, 8'h00, 32'hFFFF_FFFF);
        check("ctrl_fb", 32'(fallback_enable), 32'h1);
        check("ctrl_man", 32'(manual_enable), 32'h1);
        check("ctrl_mch", 32'(manual_channel), 32'h3);
        bus(0, 1, 8'h00, 0);
        check("rd_ctrl", mm_rdata, 32'h33);

        bus(1, 0, 8'h04, 32'h1B);
        bus(1, 0, 8'h08, 32'hFFFF_FFFF);
        check("prio_out", 32'(channel_priority), 32'h1B);
        check("timer_out", 32'(reset_timer), 32'hFFFFF);
        bus(0, 1, 8'h04, 0);
        check("rd_prio", mm_rdata, 32'h1B);
        bus(0, 1, 8'h08, 0);
        check("rd_timer", mm_rdata, 32'hFFFFF);
        idle();
        check("rdata_hold", mm_rdata, 32'hFFFFF);

        active_channel = 2; signal_present = 4'hA;
        error_count_ch0 = 8'h01; error_count_ch1 = 8'h02; error_count_ch2 = 8'h03; error_count_ch3 = 8'h04;
        bus(0, 1, 8'h0C, 0);
        check("rd_status", mm_rdata, 32'hA2);
        bus(0, 1, 8'h10, 0);
        check("rd_err", mm_rdata, 32'h04030201);

        bus(1, 0, 8'h0C, 32'h1234_5678);
        bus(1, 0, 8'h10, 32'h1234_5678);
        bus(1, 0, 8'h03, 32'h1234_5678);
        bus(1, 0, 8'h40, 32'h1234_5678);
        check("ro_ctrl", {26'h0, manual_channel, 2'b00, manual_enable, fallback_enable}, 32'h33);
        check("ro_prio", 32'(channel_priority), 32'h1B);
        check("ro_timer", 32'(reset_timer), 32'hFFFFF);
        bus(0, 1, 8'h03, 0);
        check("rd_unaligned", mm_rdata, 32'h0);
        bus(0, 1, 8'h40, 0);
        check("rd_unmapped", mm_rdata, 32'h0);
        bus(0, 1, 8'h1C, 0);
`ifdef MM_ID_REG_EN
        check("rd_id", mm_rdata, 32'h4D505453);
`else
        check("rd_id", mm_rdata, 32'h0);
`endif

        bus(1, 0, 8'h08, 32'd1000);
        bus(1, 1, 8'h08, 32'd5);
        check("rw_same_rdata", mm_rdata, 32'h3E8);
        check("rw_same_timer", 32'(reset_timer), 32'd5);

        rst = 1;
        bus(1, 1, 8'h04, 32'hFF);
        rst = 0;
        check("mid_rst_prio", 32'(channel_priority), 32'hE4);
        check("mid_rst_timer", 32'(reset_timer), 32'd1000);
        check("mid_rst_ctrl", {26'h0, manual_channel, 2'b00, manual_enable, fallback_enable}, 32'h0);
        check("mid_rst_rdata", mm_rdata, 32'h0);
        check_model("post_rst");

        for (int i = 0; i < 400; i++) begin
            bit [7:0] a;
            bit [7:0] addrs [7];
            addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h1C, 8'h00};
            addrs[6] = 8'($urandom);
            a = addrs[$urandom_range(0, 6)];
            active_channel = 2'($urandom);
            signal_present = 4'($urandom);
            error_count_ch0 = 8'($urandom); error_count_ch1 = 8'($urandom);
            error_count_ch2 = 8'($urandom); error_count_ch3 = 8'($urandom);
            rst = ($urandom_range(0, 49) == 0);
            bus(1'($urandom), 1'($urandom), a, $urandom);
            check_model("rand");
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
